serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
- Bit-serial subtract controller. Computes a - b - bin over W-bit operands, one bit per clock, LSB first.
- Sequences a single 1-bit full-subtract cell (difference/borrow pair) and a registered borrow chain.
- Used where one subtractor cell is shared across a wide operand instead of a W-bit ripple array.
- Start/busy/done handshake toward the issuing logic.

Parameters:
- W, 4, operand and result width in bits; legal range W >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request pulse/level; sampled only in IDLE
- a  input  W  minuend; latched on accepted start
- b  input  W  subtrahend; latched on accepted start
- bin  input  1  borrow-in; latched on accepted start
- diff  output  W  result a - b - bin mod 2^W; registered
- borrow  output  1  final borrow-out; registered
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result valid

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; diff=0, borrow=0, busy=0, done=0; internal operand shift regs, result shift reg, borrow flop and bit counter cleared. Reset overrides all other inputs, including mid-RUN; any partial result is discarded.
- FSM states and transitions:
  - IDLE: busy=0, done=0. If start=1 at an edge: latch a, b into shift regs, load borrow flop with bin, counter=0, go to RUN. Otherwise stay.
  - RUN: busy=1. Each edge:
    - Compute d = a0 ^ b0 ^ br and nbr = (~a0 & b0) | (~(a0 ^ b0) & br), where a0/b0 are the shift-reg LSBs and br is the borrow flop.
    - Shift the operand regs right. Shift d into the MSB of the result reg (shift right). br <= nbr. counter++.
    - On the edge where counter == W-1: go to DONE. On that same edge, load diff <= final result word and borrow <= nbr.
  - DONE: busy=1, done=1 for exactly one cycle; next edge go to IDLE unconditionally. start is ignored in DONE.
- start is ignored while busy; operand changes during RUN have no effect.
- Latency: start sampled at edge k -> W RUN cycles (edges k+1..k+W) -> done=1 during cycle after edge k+W. Next start is accepted at edge k+W+2 at the earliest.
- diff/borrow hold the last completed result until the next completion or reset; they never show partial values.
- Counter width clog2(W)+1. W=1: a single RUN cycle, then DONE.
- Arithmetic: diff equals (a - b - bin) mod 2^W. borrow=1 iff a < b + bin (unsigned).

Test Plan:
- W=4, a=5, b=3, bin=0, start 1 cycle -> busy high 5 cycles; done pulse in 5th cycle after start edge; diff=4'h2, borrow=0.
- a=3, b=5, bin=0 -> diff=4'hE, borrow=1. Then a=0, b=0, bin=1 -> diff=4'hF, borrow=1. Then a=15, b=15, bin=0 -> diff=0, borrow=0.
- Change a/b and hold start=1 throughout RUN and DONE -> result reflects the originally latched operands. Exactly one done per accepted start. The next start is accepted only after returning to IDLE.
- Back-to-back: start held high continuously -> done pulses every W+2 cycles; each result is correct; diff stable between done pulses.
- rst=1 mid-RUN (after 2 bits) -> next cycle: IDLE, diff=0, borrow=0, busy=0, no done. A subsequent 9-4 gives diff=5, borrow=0.
- W=1 build: a=0, b=1, bin=0 -> diff=1, borrow=1, done 1 cycle after the single RUN cycle.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - bin using one shared full-subtract cell, LSB first.
// Latency: start edge + W RUN cycles, done pulses in the following cycle.
// No backpressure: start is only sampled in IDLE and ignored while busy.
module serial_sub_ctrl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         borrow,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   a_sr, b_sr, res_sr;
    logic           br;
    logic [CW-1:0]  cnt;
    logic           a0, b0, d, nbr, last;
    logic [W:0]     res_cat;
    logic [W-1:0]   res_nxt;

    // Single subtract cell; the concatenation keeps the shift legal for W=1.
    always_comb begin
        a0      = a_sr[0];
        b0      = b_sr[0];
        d       = a0 ^ b0 ^ br;
        nbr     = (~a0 & b0) | (~(a0 ^ b0) & br);
        res_cat = {d, res_sr};
        res_nxt = res_cat[W:1];
        last    = (cnt == CW'(W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // diff/borrow update only on the final bit so partial results never show.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        br   <= bin;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_nxt;
                    br     <= nbr;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        diff   <= res_nxt;
                        borrow <= nbr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: W=4 and W=1 instances against an arithmetic reference.
module tb_serial_sub_ctrl;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start4 = 1'b0;
    logic [W-1:0] a4 = '0, b4 = '0;
    logic         bin4 = 1'b0;
    logic [W-1:0] diff4;
    logic         borrow4, busy4, done4;

    logic         start1 = 1'b0;
    logic         a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
    logic         diff1, borrow1, busy1, done1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_done = -1;
    bit chained = 0;
    logic [W-1:0] prev_d = '0;
    logic         prev_b = 1'b0;

    serial_sub_ctrl #(.W(W)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .diff(diff4), .borrow(borrow4), .busy(busy4), .done(done4)
    );

    serial_sub_ctrl #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .diff(diff1), .borrow(borrow1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction, wrapped to W bits; negative means borrow.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                          input bit hold, input bit keep);
        int d_i;
        int n;
        logic [W-1:0] ed;
        logic         eb;
        d_i = int'(ta) - int'(tb_v) - int'(tbin);
        ed  = W'(d_i & ((1 << W) - 1));
        eb  = (d_i < 0);

        @(negedge clk);
        a4 = ta; b4 = tb_v; bin4 = tbin; start4 = 1'b1;
        @(posedge clk); #1;
        chk("accept_busy", 32'(busy4), 32'(1));
        chk("accept_done", 32'(done4), 32'(0));
        n = 0;
        do begin
            @(negedge clk);
            start4 = hold;
            if (hold) begin
                a4 = W'($urandom); b4 = W'($urandom); bin4 = 1'($urandom);
            end
            @(posedge clk); #1;
            n++;
            if (!done4) begin
                chk("run_busy", 32'(busy4), 32'(1));
                chk("diff_stable", 32'(diff4), 32'(prev_d));
                chk("borrow_stable", 32'(borrow4), 32'(prev_b));
            end
        end while (!done4 && n < 3 * W);
        chk("latency", n, W);
        chk("diff", 32'(diff4), 32'(ed));
        chk("borrow", 32'(borrow4), 32'(eb));
        chk("done_busy", 32'(busy4), 32'(1));
        if (chained) chk("period", cyc - last_done, W + 2);
        last_done = cyc;
        chained   = keep;
        prev_d    = ed;
        prev_b    = eb;

        @(negedge clk);
        if (hold) begin
            a4 = W'($urandom); b4 = W'($urandom);
        end
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy4), 32'(0));
        chk("idle_done", 32'(done4), 32'(0));
        chk("idle_diff", 32'(diff4), 32'(ed));
        if (!keep) begin
            @(negedge clk);
            start4 = 1'b0;
            @(posedge clk); #1;
            chk("no_restart", 32'(busy4), 32'(0));
        end
    endtask

    initial begin
        int d1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_diff", 32'(diff4), 32'(0));
        chk("rst_borrow", 32'(borrow4), 32'(0));
        chk("rst_busy", 32'(busy4), 32'(0));
        chk("rst_done", 32'(done4), 32'(0));
        chk("rst_busy1", 32'(busy1), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        run_op(4'd5, 4'd3, 1'b0, 0, 0);
        run_op(4'd3, 4'd5, 1'b0, 0, 0);
        run_op(4'd0, 4'd0, 1'b1, 0, 0);
        run_op(4'd15, 4'd15, 1'b0, 0, 0);

        // Start held and operands scrambled through RUN and DONE.
        run_op(4'd6, 4'd9, 1'b1, 1, 0);

        // Back-to-back with start held continuously.
        for (int i = 0; i < 5; i++)
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1, (i != 4));

        // Reset after two RUN bits.
        @(negedge clk);
        a4 = 4'd12; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_busy", 32'(busy4), 32'(0));
        chk("mid_rst_done", 32'(done4), 32'(0));
        chk("mid_rst_diff", 32'(diff4), 32'(0));
        chk("mid_rst_borrow", 32'(borrow4), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_done", 32'(done4), 32'(0));
        chk("post_rst_busy", 32'(busy4), 32'(0));
        prev_d  = '0;
        prev_b  = 1'b0;
        chained = 0;
        run_op(4'd9, 4'd4, 1'b0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            bit h, k;
            h = 1'($urandom);
            k = 1'($urandom);
            run_op(W'($urandom), W'($urandom), 1'($urandom), h, k);
        end
        if (chained) run_op(4'd1, 4'd2, 1'b0, 0, 0);

        // W=1: every input combination.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = i[0]; b1 = i[1]; bin1 = i[2]; start1 = 1'b1;
            d1 = int'(a1) - int'(b1) - int'(bin1);
            @(posedge clk); #1;
            chk("w1_busy", 32'(busy1), 32'(1));
            chk("w1_early_done", 32'(done1), 32'(0));
            @(negedge clk);
            start1 = 1'b0;
            @(posedge clk); #1;
            chk("w1_done", 32'(done1), 32'(1));
            chk("w1_diff", 32'(diff1), 32'(d1 & 1));
            chk("w1_borrow", 32'(borrow1), 32'(d1 < 0));
            @(posedge clk); #1;
            chk("w1_idle", 32'(busy1), 32'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
